// File: rtl/btn_debounce_pulse_pkg.sv
// Shared definitions for the push-button conditioning block.
//   state_t           : debounce FSM state encoding (2 bits)
//   DEBOUNCE_DEFAULT  : stable cycles for a 10 ms window at 100 MHz
//   DEBOUNCE_SIM      : short window used in simulation
package btn_debounce_pulse_pkg;

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESS_CHK   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_CHK = 2'd3
   } state_t;

   localparam int DEBOUNCE_DEFAULT = 1000000;
   localparam int DEBOUNCE_SIM     = 4;

endpackage

// File: rtl/btn_debounce_pulse_sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit pin.
// Reusable for any pin input.
//   clk : sampling clock
//   rst : asynchronous active-low clear of every stage
//   d   : asynchronous input
//   q   : synchronised output (last stage of the chain)
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchronises the raw pin, qualifies every level
// change with a stability counter and emits single-cycle press/release strobes.
// press_pulse drives the toggle stage input directly.
//   clk           : system clock
//   rst           : asynchronous active-low reset
//   btn_raw       : raw button pin, 1 = pressed
//   btn_level     : debounced level (registered)
//   press_pulse   : one-cycle strobe on accepted 0->1 change
//   release_pulse : one-cycle strobe on accepted 1->0 change
//
// state       | meaning
// ------------+---------------------------------------------------
// RELEASED    | stable low, waiting for synchronised input to rise
// PRESS_CHK   | input high, counting consecutive high cycles
// PRESSED     | stable high, waiting for synchronised input to fall
// RELEASE_CHK | input low, counting consecutive low cycles
module btn_debounce_pulse
   import btn_debounce_pulse_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             btn_sync;
   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             level_nxt, press_nxt, release_nxt;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_raw),
      .q   (btn_sync)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= RELEASED;
         cnt           <= '0;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         btn_level     <= level_nxt;
         press_pulse   <= press_nxt;
         release_pulse <= release_nxt;
      end
   end

   // The entry into a CHK state already counts as the first stable cycle,
   // so cnt starts at 1 and the transition fires when it reaches the last value.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      level_nxt   = btn_level;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      case (state)
         RELEASED: begin
            if (btn_sync) begin
               state_nxt = PRESS_CHK;
               cnt_nxt   = CNT_ONE;
            end
         end
         PRESS_CHK: begin
            if (!btn_sync) begin
               state_nxt = RELEASED;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = PRESSED;
               cnt_nxt   = '0;
               level_nxt = 1'b1;
               press_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         PRESSED: begin
            if (!btn_sync) begin
               state_nxt = RELEASE_CHK;
               cnt_nxt   = CNT_ONE;
            end
         end
         RELEASE_CHK: begin
            if (btn_sync) begin
               state_nxt = PRESSED;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt   = RELEASED;
               cnt_nxt     = '0;
               level_nxt   = 1'b0;
               release_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
            level_nxt = 1'b0;
         end
      endcase
   end

endmodule
